// File: rtl/sys_ctrl_gen2_if.sv
// Bundles the system controller's data-path signals.
// master: the controller; slave: its surroundings (UART RX, register file, ALU, TX FIFO).
interface sys_ctrl_gen2_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]    RX_P_DATA;
    logic                     RX_D_VLD;
    logic                     FIFO_FULL;
    logic [2*DATA_WIDTH-1:0]  ALU_OUT;
    logic                     OUT_Valid;
    logic [DATA_WIDTH-1:0]    Rd_D;
    logic                     Rd_D_Vld;

    logic [DATA_WIDTH-1:0]    WR_DATA;
    logic                     WR_INC;
    logic                     ALU_EN;
    logic [ALU_FUN_WIDTH-1:0] ALU_FUN;
    logic                     CLK_EN;
    logic [DATA_WIDTH-1:0]    Wr_D;
    logic [ADDR_WIDTH-1:0]    Addr;
    logic                     WrEn;
    logic                     RdEn;
    logic                     CLK_DIV_EN;
    logic                     ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, FIFO_FULL, ALU_OUT, OUT_Valid, Rd_D, Rd_D_Vld,
        output WR_DATA, WR_INC, ALU_EN, ALU_FUN, CLK_EN, Wr_D, Addr, WrEn, RdEn,
               CLK_DIV_EN, ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, FIFO_FULL, ALU_OUT, OUT_Valid, Rd_D, Rd_D_Vld,
        input  WR_DATA, WR_INC, ALU_EN, ALU_FUN, CLK_EN, Wr_D, Addr, WrEn, RdEn,
               CLK_DIV_EN, ERR
    );
endinterface

// File: rtl/sys_ctrl_gen2.sv
// Command decoder/sequencer between UART RX, register file, ALU and TX FIFO.
// Define SYS_CTRL_BURST_EN to add the 0xEE auto-incrementing burst-write command.
module sys_ctrl_gen2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic            CLK,
    input  logic            RST,
    sys_ctrl_gen2_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);
`ifdef SYS_CTRL_BURST_EN
    localparam logic [DATA_WIDTH-1:0] CMD_BURST   = DATA_WIDTH'(8'hEE);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_ALU_A,
        S_ALU_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_PUSH
`ifdef SYS_CTRL_BURST_EN
        , S_BURST_ADDR,
        S_BURST_CNT,
        S_BURST_DATA
`endif
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          tmo_cnt;
    logic [2*DATA_WIDTH-1:0]   resp;
    logic [1:0]                words_left;

    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      wr_inc;
    logic                      alu_en;
    logic [ALU_FUN_WIDTH-1:0]  alu_fun;
    logic                      clk_en;
    logic [DATA_WIDTH-1:0]     wr_d;
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      wr_en;
    logic                      rd_en;
    logic                      clk_div_en;
    logic                      err;

`ifdef SYS_CTRL_BURST_EN
    logic [ADDR_WIDTH-1:0]     burst_addr;
    logic [ADDR_WIDTH:0]       burst_left;
`endif

    logic [ADDR_WIDTH-1:0]     rx_addr;
    logic                      cap_vld;
    logic [2*DATA_WIDTH-1:0]   cap_data;
    logic [1:0]                cap_words;

    assign rx_addr = bus.RX_P_DATA[ADDR_WIDTH-1:0];

    // Response source for whichever wait state is active: read = 1 word, ALU = 2 words.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cap_vld   = 1'b0;
        cap_data  = {{DATA_WIDTH{1'b0}}, bus.Rd_D};
        cap_words = 2'd1;
        if (state == S_ALU_WAIT) begin
            cap_vld   = bus.OUT_Valid;
            cap_data  = bus.ALU_OUT;
            cap_words = 2'd2;
        end else if (state == S_RD_WAIT) begin
            cap_vld   = bus.Rd_D_Vld;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every output is a clean flop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            resp       <= '0;
            words_left <= '0;
            wr_data    <= '0;
            wr_inc     <= 1'b0;
            alu_en     <= 1'b0;
            alu_fun    <= '0;
            clk_en     <= 1'b0;
            wr_d       <= '0;
            addr       <= '0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            clk_div_en <= 1'b0;
            err        <= 1'b0;
`ifdef SYS_CTRL_BURST_EN
            burst_addr <= '0;
            burst_left <= '0;
`endif
        end else begin
            clk_div_en <= 1'b1;
            wr_inc     <= 1'b0;
            alu_en     <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            err        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.RX_D_VLD) begin
                        case (bus.RX_P_DATA)
                            CMD_WR:      state <= S_WR_ADDR;
                            CMD_RD:      state <= S_RD_ADDR;
                            CMD_ALU_OP:  state <= S_ALU_A;
                            CMD_ALU_NOP: state <= S_ALU_FUN;
`ifdef SYS_CTRL_BURST_EN
                            CMD_BURST:   state <= S_BURST_ADDR;
`endif
                            default:     err   <= 1'b1;
                        endcase
                    end
                end

                S_WR_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        addr  <= rx_addr;
                        state <= S_WR_DATA;
                    end
                end

                S_WR_DATA: begin
                    if (bus.RX_D_VLD) begin
                        wr_en <= 1'b1;
                        wr_d  <= bus.RX_P_DATA;
                        state <= S_IDLE;
                    end
                end

                S_RD_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        addr    <= rx_addr;
                        rd_en   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= S_RD_WAIT;
                    end
                end

                S_ALU_A: begin
                    if (bus.RX_D_VLD) begin
                        wr_en <= 1'b1;
                        addr  <= '0;
                        wr_d  <= bus.RX_P_DATA;
                        state <= S_ALU_B;
                    end
                end

                S_ALU_B: begin
                    if (bus.RX_D_VLD) begin
                        wr_en <= 1'b1;
                        addr  <= ADDR_WIDTH'(1);
                        wr_d  <= bus.RX_P_DATA;
                        state <= S_ALU_FUN;
                    end
                end

                S_ALU_FUN: begin
                    if (bus.RX_D_VLD) begin
                        alu_fun <= bus.RX_P_DATA[ALU_FUN_WIDTH-1:0];
                        alu_en  <= 1'b1;
                        clk_en  <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= S_ALU_WAIT;
                    end
                end

                // Valid is tested before the timeout so a coincident valid wins.
                S_RD_WAIT, S_ALU_WAIT: begin
                    if (bus.RX_D_VLD) err <= 1'b1;
                    if (cap_vld) begin
                        clk_en <= 1'b0;
                        if (!bus.FIFO_FULL) begin
                            wr_inc     <= 1'b1;
                            wr_data    <= cap_data[DATA_WIDTH-1:0];
                            resp       <= cap_data >> DATA_WIDTH;
                            words_left <= cap_words - 2'd1;
                            state      <= (cap_words == 2'd1) ? S_IDLE : S_PUSH;
                        end else begin
                            resp       <= cap_data;
                            words_left <= cap_words;
                            state      <= S_PUSH;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err    <= 1'b1;
                        clk_en <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                S_PUSH: begin
                    if (bus.RX_D_VLD) err <= 1'b1;
                    if (!bus.FIFO_FULL) begin
                        wr_inc     <= 1'b1;
                        wr_data    <= resp[DATA_WIDTH-1:0];
                        resp       <= resp >> DATA_WIDTH;
                        words_left <= words_left - 2'd1;
                        if (words_left == 2'd1) state <= S_IDLE;
                    end
                end

`ifdef SYS_CTRL_BURST_EN
                S_BURST_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        burst_addr <= rx_addr;
                        state      <= S_BURST_CNT;
                    end
                end

                // A count of zero encodes the full 2^ADDR_WIDTH range.
                S_BURST_CNT: begin
                    if (bus.RX_D_VLD) begin
                        burst_left <= (rx_addr == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                                      : {1'b0, rx_addr};
                        state      <= S_BURST_DATA;
                    end
                end

                S_BURST_DATA: begin
                    if (bus.RX_D_VLD) begin
                        wr_en      <= 1'b1;
                        addr       <= burst_addr;
                        wr_d       <= bus.RX_P_DATA;
                        burst_addr <= burst_addr + ADDR_WIDTH'(1);
                        burst_left <= burst_left - (ADDR_WIDTH + 1)'(1);
                        if (burst_left == (ADDR_WIDTH + 1)'(1)) state <= S_IDLE;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.WR_DATA    = wr_data;
    assign bus.WR_INC     = wr_inc;
    assign bus.ALU_EN     = alu_en;
    assign bus.ALU_FUN    = alu_fun;
    assign bus.CLK_EN     = clk_en;
    assign bus.Wr_D       = wr_d;
    assign bus.Addr       = addr;
    assign bus.WrEn       = wr_en;
    assign bus.RdEn       = rd_en;
    assign bus.CLK_DIV_EN = clk_div_en;
    assign bus.ERR        = err;
endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// Directed self-checking bench for sys_ctrl_gen2 (TIMEOUT = 16).
// Burst checks follow SYS_CTRL_BURST_EN so the bench matches either build.
module tb_sys_ctrl_gen2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_cnt = 0;
    logic [7:0] push_q[$];

    sys_ctrl_gen2_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4)) bus ();

    sys_ctrl_gen2 #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT(16)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.WR_INC === 1'b1) push_q.push_back(bus.WR_DATA);
        if (bus.ERR === 1'b1) err_cnt++;
    end

    function automatic logic [29:0] outs();
        return {bus.WR_DATA, bus.WR_INC, bus.ALU_EN, bus.ALU_FUN, bus.CLK_EN,
                bus.Wr_D, bus.Addr, bus.WrEn, bus.RdEn, bus.ERR};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        bus.RX_P_DATA = w;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (outs() !== 30'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs()); end
        n_checks++; if (bus.CLK_DIV_EN !== 1'b0) begin n_fail++; $display("FAIL reset_clk_div_en: got %b expected 0", bus.CLK_DIV_EN); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.CLK_DIV_EN !== 1'b1) begin n_fail++; $display("FAIL clk_div_en_after_release: got %b expected 1", bus.CLK_DIV_EN); end
    endtask

    task automatic test_write();
        send_word(8'hAA);
        send_word(8'h05);
        n_checks++; if (bus.WrEn !== 1'b0) begin n_fail++; $display("FAIL write_early_wren: got %b expected 0", bus.WrEn); end
        send_word(8'h3C);
        n_checks++; if (bus.WrEn !== 1'b1) begin n_fail++; $display("FAIL write_wren: got %b expected 1", bus.WrEn); end
        n_checks++; if (bus.Addr !== 4'h5) begin n_fail++; $display("FAIL write_addr: got %h expected 5", bus.Addr); end
        n_checks++; if (bus.Wr_D !== 8'h3C) begin n_fail++; $display("FAIL write_data: got %h expected 3c", bus.Wr_D); end
        tick();
        n_checks++; if (bus.WrEn !== 1'b0) begin n_fail++; $display("FAIL write_wren_one_cycle: got %b expected 0", bus.WrEn); end
    endtask

    task automatic test_read();
        int base = push_q.size();
        send_word(8'hBB);
        send_word(8'h05);
        n_checks++; if (bus.RdEn !== 1'b1) begin n_fail++; $display("FAIL read_rden: got %b expected 1", bus.RdEn); end
        n_checks++; if (bus.Addr !== 4'h5) begin n_fail++; $display("FAIL read_addr: got %h expected 5", bus.Addr); end
        tick();
        n_checks++; if (bus.RdEn !== 1'b0) begin n_fail++; $display("FAIL read_rden_one_cycle: got %b expected 0", bus.RdEn); end
        tick();
        bus.Rd_D = 8'h3C;
        bus.Rd_D_Vld = 1'b1;
        tick();
        bus.Rd_D_Vld = 1'b0;
        n_checks++; if (bus.WR_INC !== 1'b1) begin n_fail++; $display("FAIL read_push: got %b expected 1", bus.WR_INC); end
        n_checks++; if (bus.WR_DATA !== 8'h3C) begin n_fail++; $display("FAIL read_push_data: got %h expected 3c", bus.WR_DATA); end
        repeat (3) tick();
        n_checks++; if (push_q.size() !== base + 1) begin n_fail++; $display("FAIL read_push_count: got %0d expected %0d", push_q.size(), base + 1); end
    endtask

    task automatic test_alu_operands();
        int base = push_q.size();
        int stall_pushes = 0;
        send_word(8'hCC);
        send_word(8'h0A);
        n_checks++; if ({bus.WrEn, bus.Addr, bus.Wr_D} !== {1'b1, 4'h0, 8'h0A}) begin n_fail++; $display("FAIL alu_opa_write: got %h expected 100a", {bus.WrEn, bus.Addr, bus.Wr_D}); end
        send_word(8'h03);
        n_checks++; if ({bus.WrEn, bus.Addr, bus.Wr_D} !== {1'b1, 4'h1, 8'h03}) begin n_fail++; $display("FAIL alu_opb_write: got %h expected 1103", {bus.WrEn, bus.Addr, bus.Wr_D}); end
        send_word(8'h02);
        n_checks++; if ({bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN} !== {1'b1, 1'b1, 4'h2}) begin n_fail++; $display("FAIL alu_start: got %h expected 32", {bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN}); end
        tick();
        n_checks++; if ({bus.ALU_EN, bus.CLK_EN} !== 2'b01) begin n_fail++; $display("FAIL alu_en_one_cycle: got %b expected 01", {bus.ALU_EN, bus.CLK_EN}); end
        tick();
        bus.ALU_OUT = 16'h001E;
        bus.OUT_Valid = 1'b1;
        tick();
        bus.OUT_Valid = 1'b0;
        bus.FIFO_FULL = 1'b1;
        n_checks++; if ({bus.WR_INC, bus.WR_DATA} !== {1'b1, 8'h1E}) begin n_fail++; $display("FAIL alu_push_low: got %h expected 11e", {bus.WR_INC, bus.WR_DATA}); end
        n_checks++; if (bus.CLK_EN !== 1'b0) begin n_fail++; $display("FAIL alu_clk_en_drop: got %b expected 0", bus.CLK_EN); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.WR_INC === 1'b1) stall_pushes++;
        end
        n_checks++; if (stall_pushes !== 0) begin n_fail++; $display("FAIL alu_full_hold: got %0d pushes expected 0", stall_pushes); end
        bus.FIFO_FULL = 1'b0;
        tick();
        n_checks++; if ({bus.WR_INC, bus.WR_DATA} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL alu_push_high: got %h expected 100", {bus.WR_INC, bus.WR_DATA}); end
        tick();
        n_checks++; if (bus.WR_INC !== 1'b0) begin n_fail++; $display("FAIL alu_push_done: got %b expected 0", bus.WR_INC); end
        tick();
        n_checks++; if (push_q.size() !== base + 2) begin n_fail++; $display("FAIL alu_push_count: got %0d expected %0d", push_q.size(), base + 2); end
        else begin
            n_checks++; if ({push_q[base], push_q[base+1]} !== 16'h1E00) begin n_fail++; $display("FAIL alu_push_order: got %h expected 1e00", {push_q[base], push_q[base+1]}); end
        end
    endtask

    task automatic test_alu_no_operands();
        send_word(8'hDD);
        send_word(8'h05);
        n_checks++; if ({bus.ALU_EN, bus.ALU_FUN, bus.WrEn} !== {1'b1, 4'h5, 1'b0}) begin n_fail++; $display("FAIL nop_start: got %h expected 2a", {bus.ALU_EN, bus.ALU_FUN, bus.WrEn}); end
        bus.FIFO_FULL = 1'b1;
        bus.ALU_OUT = 16'hA55A;
        bus.OUT_Valid = 1'b1;
        tick();
        bus.OUT_Valid = 1'b0;
        n_checks++; if ({bus.WR_INC, bus.CLK_EN} !== 2'b00) begin n_fail++; $display("FAIL nop_full_capture: got %b expected 00", {bus.WR_INC, bus.CLK_EN}); end
        send_word(8'h33);
        n_checks++; if ({bus.ERR, bus.WR_INC} !== 2'b10) begin n_fail++; $display("FAIL push_rx_drop_err: got %b expected 10", {bus.ERR, bus.WR_INC}); end
        bus.FIFO_FULL = 1'b0;
        tick();
        n_checks++; if ({bus.WR_INC, bus.WR_DATA} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL nop_push_low: got %h expected 15a", {bus.WR_INC, bus.WR_DATA}); end
        tick();
        n_checks++; if ({bus.WR_INC, bus.WR_DATA} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL nop_push_high: got %h expected 1a5", {bus.WR_INC, bus.WR_DATA}); end
        tick();
        n_checks++; if (bus.WR_INC !== 1'b0) begin n_fail++; $display("FAIL nop_push_done: got %b expected 0", bus.WR_INC); end
    endtask

    task automatic test_timeout();
        int base = push_q.size();
        send_word(8'hBB);
        send_word(8'h02);
        err_cnt = 0;
        n_checks++; if (bus.RdEn !== 1'b1) begin n_fail++; $display("FAIL tmo_rden: got %b expected 1", bus.RdEn); end
        repeat (15) tick();
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL tmo_early_err: got %b expected 0", bus.ERR); end
        tick();
        n_checks++; if (bus.ERR !== 1'b1) begin n_fail++; $display("FAIL tmo_err_at_16: got %b expected 1", bus.ERR); end
        tick();
        n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL tmo_err_pulses: got %0d expected 1", err_cnt); end
        n_checks++; if (push_q.size() !== base) begin n_fail++; $display("FAIL tmo_no_push: got %0d expected %0d", push_q.size(), base); end

        send_word(8'hAA);
        send_word(8'h07);
        send_word(8'h99);
        n_checks++; if ({bus.WrEn, bus.Addr, bus.Wr_D} !== {1'b1, 4'h7, 8'h99}) begin n_fail++; $display("FAIL tmo_recover_write: got %h expected 1799", {bus.WrEn, bus.Addr, bus.Wr_D}); end
        send_word(8'h77);
        n_checks++; if (bus.ERR !== 1'b1) begin n_fail++; $display("FAIL unknown_cmd_err: got %b expected 1", bus.ERR); end

        // Valid arriving on the expiry cycle must win over the timeout.
        send_word(8'hBB);
        send_word(8'h03);
        repeat (15) tick();
        bus.Rd_D = 8'h5A;
        bus.Rd_D_Vld = 1'b1;
        tick();
        bus.Rd_D_Vld = 1'b0;
        n_checks++; if ({bus.ERR, bus.WR_INC, bus.WR_DATA} !== {1'b0, 1'b1, 8'h5A}) begin n_fail++; $display("FAIL tmo_valid_wins: got %h expected 15a", {bus.ERR, bus.WR_INC, bus.WR_DATA}); end

        send_word(8'hDD);
        send_word(8'h01);
        repeat (15) tick();
        n_checks++; if ({bus.ERR, bus.CLK_EN} !== 2'b01) begin n_fail++; $display("FAIL alu_tmo_early: got %b expected 01", {bus.ERR, bus.CLK_EN}); end
        tick();
        n_checks++; if ({bus.ERR, bus.CLK_EN} !== 2'b10) begin n_fail++; $display("FAIL alu_tmo_err: got %b expected 10", {bus.ERR, bus.CLK_EN}); end
    endtask

    task automatic test_burst();
`ifdef SYS_CTRL_BURST_EN
        send_word(8'hEE);
        send_word(8'h0E);
        send_word(8'h03);
        send_word(8'h11);
        n_checks++; if ({bus.WrEn, bus.Addr, bus.Wr_D} !== {1'b1, 4'hE, 8'h11}) begin n_fail++; $display("FAIL burst_w0: got %h expected 1e11", {bus.WrEn, bus.Addr, bus.Wr_D}); end
        send_word(8'h22);
        n_checks++; if ({bus.WrEn, bus.Addr, bus.Wr_D} !== {1'b1, 4'hF, 8'h22}) begin n_fail++; $display("FAIL burst_w1: got %h expected 1f22", {bus.WrEn, bus.Addr, bus.Wr_D}); end
        send_word(8'h33);
        n_checks++; if ({bus.WrEn, bus.Addr, bus.Wr_D} !== {1'b1, 4'h0, 8'h33}) begin n_fail++; $display("FAIL burst_wrap: got %h expected 1033", {bus.WrEn, bus.Addr, bus.Wr_D}); end
        send_word(8'h44);
        n_checks++; if ({bus.WrEn, bus.ERR} !== 2'b01) begin n_fail++; $display("FAIL burst_end_idle: got %b expected 01", {bus.WrEn, bus.ERR}); end
`else
        send_word(8'hEE);
        n_checks++; if (bus.ERR !== 1'b1) begin n_fail++; $display("FAIL burst_off_err: got %b expected 1", bus.ERR); end
        tick();
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL burst_off_err_pulse: got %b expected 0", bus.ERR); end
`endif
    endtask

    task automatic test_reset_mid();
        int base;
        send_word(8'hDD);
        send_word(8'h03);
        tick();
        n_checks++; if (bus.CLK_EN !== 1'b1) begin n_fail++; $display("FAIL mid_pre_clk_en: got %b expected 1", bus.CLK_EN); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({outs(), bus.CLK_DIV_EN} !== 31'd0) begin n_fail++; $display("FAIL mid_reset_async: got %h expected 0", {outs(), bus.CLK_DIV_EN}); end
        base = push_q.size();
        bus.ALU_OUT = 16'h1234;
        bus.OUT_Valid = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        bus.OUT_Valid = 1'b0;
        repeat (2) tick();
        n_checks++; if (push_q.size() !== base) begin n_fail++; $display("FAIL mid_no_push: got %0d expected %0d", push_q.size(), base); end
        n_checks++; if ({bus.CLK_EN, bus.CLK_DIV_EN} !== 2'b01) begin n_fail++; $display("FAIL mid_after_release: got %b expected 01", {bus.CLK_EN, bus.CLK_DIV_EN}); end
    endtask

    initial begin
        bus.RX_P_DATA = '0;
        bus.RX_D_VLD  = 1'b0;
        bus.FIFO_FULL = 1'b0;
        bus.ALU_OUT   = '0;
        bus.OUT_Valid = 1'b0;
        bus.Rd_D      = '0;
        bus.Rd_D_Vld  = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_alu_operands();
        test_alu_no_operands();
        test_timeout();
        test_burst();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
